// File: rtl/prog_loader_arb_pkg.sv
// Shared definitions for the boot loader / memory arbiter and the accumulator CPU.
package prog_loader_arb_pkg;

    localparam int DEF_AW    = 5;
    localparam int DEF_DW    = 8;
    localparam int DEF_DEPTH = 1 << DEF_AW;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_RUN    = 2'd2,
        ST_HALTED = 2'd3
    } pl_state_t;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_LOADER = 2'd1,
        OWN_CPU_RW = 2'd2,
        OWN_CPU_RO = 2'd3
    } mem_owner_t;

    // The memory owner depends on the state alone, so two masters can never collide.
    function automatic mem_owner_t owner_of(input pl_state_t st);
        mem_owner_t own;
        case (st)
            ST_LOAD:   own = OWN_LOADER;
            ST_RUN:    own = OWN_CPU_RW;
            ST_HALTED: own = OWN_CPU_RO;
            default:   own = OWN_NONE;
        endcase
        return own;
    endfunction

endpackage

// File: rtl/prog_loader_arb_mem_port_mux.sv
// Combinational owner select for the single shared memory port.
module prog_loader_arb_mem_port_mux
    import prog_loader_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  mem_owner_t      owner,
    input  logic [AW-1:0]   ld_addr,
    input  logic [DW-1:0]   ld_data,
    input  logic            ld_we,
    input  logic [AW-1:0]   cpu_addr,
    input  logic            cpu_we,
    input  logic [DW-1:0]   cpu_wdata,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_we,
    output logic [DW-1:0]   mem_wdata
);

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (owner)
            OWN_LOADER: begin
                mem_addr  = ld_addr;
                mem_we    = ld_we;
                mem_wdata = ld_data;
            end
            OWN_CPU_RW: begin
                mem_addr  = cpu_addr;
                mem_we    = cpu_we;
                mem_wdata = cpu_wdata;
            end
            // Halted CPU keeps the address path for inspection but cannot write.
            OWN_CPU_RO: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            default: begin
                mem_addr  = '0;
                mem_we    = 1'b0;
                mem_wdata = '0;
            end
        endcase
    end

endmodule

// File: rtl/prog_loader_arb.sv
// Boot loader and memory arbiter: streams a program image into memory, then runs and parks the CPU.
//   state  | meaning
//   IDLE   | CPU held in reset, memory port idle, waiting for ld_start
//   LOAD   | loader owns memory, one byte per accepted handshake
//   RUN    | CPU released and owns memory
//   HALTED | CPU stopped but visible; restart or reload from here
module prog_loader_arb
    import prog_loader_arb_pkg::*;
#(
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ld_start,
    input  logic            ld_valid,
    input  logic [DW-1:0]   ld_data,
    input  logic            ld_last,
    output logic            ld_ready,
    input  logic            restart,
    input  logic            cpu_halt,
    input  logic [AW-1:0]   cpu_addr,
    input  logic            cpu_we,
    input  logic [DW-1:0]   cpu_wdata,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_we,
    output logic [DW-1:0]   mem_wdata,
    output logic            cpu_rst_n,
    output logic            cpu_run,
    output logic [AW:0]     img_len,
    output logic            ovf,
    output logic [1:0]      state
);

    localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

    pl_state_t   st;
    logic [AW:0] cnt;
    logic        rst_pend;
    logic        xfer;
    logic        final_xfer;

    assign xfer       = ld_valid && ld_ready;
    assign final_xfer = xfer && (ld_last || (cnt == LAST_IDX));
    assign state      = st;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st        <= ST_IDLE;
            cnt       <= '0;
            img_len   <= '0;
            ovf       <= 1'b0;
            cpu_rst_n <= 1'b0;
            cpu_run   <= 1'b0;
            ld_ready  <= 1'b0;
            rst_pend  <= 1'b0;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (ld_start) begin
                        st       <= ST_LOAD;
                        cnt      <= '0;
                        img_len  <= '0;
                        ovf      <= 1'b0;
                        ld_ready <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        cnt <= cnt + 1'b1;
                    end
                    // Reaching the last word without ld_last means the image was cut short.
                    if (final_xfer) begin
                        st        <= ST_RUN;
                        img_len   <= cnt + 1'b1;
                        ovf       <= !ld_last;
                        ld_ready  <= 1'b0;
                        cpu_rst_n <= 1'b1;
                        cpu_run   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cpu_halt) begin
                        st      <= ST_HALTED;
                        cpu_run <= 1'b0;
                    end
                end
                ST_HALTED: begin
                    if (rst_pend) begin
                        st        <= ST_RUN;
                        rst_pend  <= 1'b0;
                        cpu_rst_n <= 1'b1;
                        cpu_run   <= 1'b1;
                    end else if (ld_start) begin
                        st        <= ST_LOAD;
                        cnt       <= '0;
                        img_len   <= '0;
                        ovf       <= 1'b0;
                        ld_ready  <= 1'b1;
                        cpu_rst_n <= 1'b0;
                    end else if (restart) begin
                        // One reset cycle for the CPU while still parked, then run.
                        rst_pend  <= 1'b1;
                        cpu_rst_n <= 1'b0;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    prog_loader_arb_mem_port_mux #(
        .AW (AW),
        .DW (DW)
    ) u_mux (
        .owner     (owner_of(st)),
        .ld_addr   (cnt[AW-1:0]),
        .ld_data   (ld_data),
        .ld_we     (xfer),
        .cpu_addr  (cpu_addr),
        .cpu_we    (cpu_we),
        .cpu_wdata (cpu_wdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata)
    );

endmodule

// File: tb/tb_prog_loader_arb.sv
// Self-checking bench for prog_loader_arb: vector tables, scoreboarded memory writes, corner sequences.
module tb_prog_loader_arb;
    import prog_loader_arb_pkg::*;

    localparam int AW = 5;
    localparam int DW = 8;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            ld_start = 1'b0;
    logic            ld_valid = 1'b0;
    logic [DW-1:0]   ld_data = '0;
    logic            ld_last = 1'b0;
    logic            ld_ready;
    logic            restart = 1'b0;
    logic            cpu_halt = 1'b0;
    logic [AW-1:0]   cpu_addr = '0;
    logic            cpu_we = 1'b0;
    logic [DW-1:0]   cpu_wdata = '0;
    logic [AW-1:0]   mem_addr;
    logic            mem_we;
    logic [DW-1:0]   mem_wdata;
    logic            cpu_rst_n;
    logic            cpu_run;
    logic [AW:0]     img_len;
    logic            ovf;
    logic [1:0]      state;

    prog_loader_arb dut (
        .clock     (clock),
        .reset     (reset),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .restart   (restart),
        .cpu_halt  (cpu_halt),
        .cpu_addr  (cpu_addr),
        .cpu_we    (cpu_we),
        .cpu_wdata (cpu_wdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .cpu_rst_n (cpu_rst_n),
        .cpu_run   (cpu_run),
        .img_len   (img_len),
        .ovf       (ovf),
        .state     (state)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       l;
        logic [1:0] st;
        logic       rdy;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [12:0] sb_q[$];
    logic [12:0] sb_exp;
    vec_t        vecs[$];
    int          m_cnt = 0;
    bit          m_loading = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every memory write must match the next expected write, in order.
    always @(negedge clock) begin
        if (reset && mem_we) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
            end else begin
                sb_exp = sb_q.pop_front();
                chk("mem_write", {19'd0, mem_addr, mem_wdata}, {19'd0, sb_exp});
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic drive_byte(input logic v, input logic [7:0] d, input logic l);
        ld_valid = v;
        ld_data  = d;
        ld_last  = l;
        if (v && m_loading) begin
            sb_q.push_back({m_cnt[4:0], d});
            m_cnt++;
            if (l || m_cnt == 32) m_loading = 1'b0;
        end
        tick();
    endtask

    task automatic run_vecs(input string name);
        for (int i = 0; i < vecs.size(); i++) begin
            drive_byte(vecs[i].v, vecs[i].d, vecs[i].l);
            chk({name, "_state"}, 32'(state), 32'(vecs[i].st));
            chk({name, "_ready"}, 32'(ld_ready), 32'(vecs[i].rdy));
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        vecs.delete();
    endtask

    task automatic start_load(input string name);
        ld_start = 1'b1;
        tick();
        ld_start  = 1'b0;
        m_loading = 1'b1;
        m_cnt     = 0;
        chk({name, "_state"}, 32'(state), 32'd1);
        chk({name, "_ready"}, 32'(ld_ready), 32'd1);
        chk({name, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
    endtask

    task automatic check_run_entry(input string name, input int len, input logic o);
        chk({name, "_state"}, 32'(state), 32'd2);
        chk({name, "_ready"}, 32'(ld_ready), 32'd0);
        chk({name, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd1);
        chk({name, "_cpu_run"}, 32'(cpu_run), 32'd1);
        chk({name, "_img_len"}, 32'(img_len), 32'(len));
        chk({name, "_ovf"}, 32'(ovf), 32'(o));
    endtask

    task automatic do_halt(input string name);
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        chk({name, "_state"}, 32'(state), 32'd3);
        chk({name, "_cpu_run"}, 32'(cpu_run), 32'd0);
        chk({name, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd1);
    endtask

    initial begin
        // Reset held from time zero
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        #12 reset = 1'b1;
        tick();
        tick();
        chk("post_rst_idle", 32'(state), 32'd0);
        chk("idle_mem_addr", 32'(mem_addr), 32'd0);

        // Reset asserted in the middle of a load
        start_load("rstmid_start");
        drive_byte(1'b1, 8'h55, 1'b0);
        drive_byte(1'b1, 8'h66, 1'b0);
        ld_valid  = 1'b0;
        m_loading = 1'b0;
        reset     = 1'b0;
        #1;
        chk("rstmid_state", 32'(state), 32'd0);
        chk("rstmid_ld_ready", 32'(ld_ready), 32'd0);
        chk("rstmid_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("rstmid_cpu_run", 32'(cpu_run), 32'd0);
        chk("rstmid_mem_we", 32'(mem_we), 32'd0);
        chk("rstmid_img_len", 32'(img_len), 32'd0);
        chk("rstmid_ovf", 32'(ovf), 32'd0);
        #1 reset = 1'b1;
        tick();
        tick();
        chk("rstmid_release_idle", 32'(state), 32'd0);

        // Normal 4-byte image
        start_load("norm_start");
        vecs.push_back('{1'b1, 8'hA3, 1'b0, 2'd1, 1'b1});
        vecs.push_back('{1'b1, 8'h04, 1'b0, 2'd1, 1'b1});
        vecs.push_back('{1'b1, 8'hE0, 1'b0, 2'd1, 1'b1});
        vecs.push_back('{1'b1, 8'h00, 1'b1, 2'd2, 1'b0});
        run_vecs("norm");
        check_run_entry("norm_run", 4, 1'b0);

        // 3-byte image with two-cycle valid gaps
        do_halt("halt1");
        start_load("stall_start");
        vecs.push_back('{1'b1, 8'h11, 1'b0, 2'd1, 1'b1});
        vecs.push_back('{1'b0, 8'hFF, 1'b0, 2'd1, 1'b1});
        vecs.push_back('{1'b0, 8'hFE, 1'b1, 2'd1, 1'b1});
        vecs.push_back('{1'b1, 8'h22, 1'b0, 2'd1, 1'b1});
        vecs.push_back('{1'b0, 8'hFD, 1'b0, 2'd1, 1'b1});
        vecs.push_back('{1'b0, 8'hFC, 1'b1, 2'd1, 1'b1});
        vecs.push_back('{1'b1, 8'h33, 1'b1, 2'd2, 1'b0});
        run_vecs("stall");
        check_run_entry("stall_run", 3, 1'b0);

        // 40 bytes without ld_last: truncated at 32
        do_halt("halt2");
        start_load("ovf_start");
        for (int i = 0; i < 40; i++) begin
            drive_byte(1'b1, 8'(i * 7 + 1), 1'b0);
            if (i == 30 || i == 31 || i == 39) begin
                chk("ovf_state", 32'(state), (i < 31) ? 32'd1 : 32'd2);
                chk("ovf_ready", 32'(ld_ready), (i < 31) ? 32'd1 : 32'd0);
            end
        end
        ld_valid = 1'b0;
        check_run_entry("ovf_run", 32, 1'b1);

        // CPU write pass-through in RUN
        cpu_addr  = 5'h1F;
        cpu_wdata = 8'h5A;
        cpu_we    = 1'b1;
        sb_q.push_back({5'h1F, 8'h5A});
        #1;
        chk("run_mem_we", 32'(mem_we), 32'd1);
        chk("run_mem_addr", 32'(mem_addr), 32'h1F);
        chk("run_mem_wdata", 32'(mem_wdata), 32'h5A);
        tick();
        cpu_we = 1'b0;

        // Halt, then restart with a one-cycle CPU reset
        do_halt("halt3");
        cpu_we = 1'b1;
        #1;
        chk("halted_mem_we", 32'(mem_we), 32'd0);
        chk("halted_mem_addr", 32'(mem_addr), 32'h1F);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        cpu_we  = 1'b0;
        chk("restart_state", 32'(state), 32'd3);
        chk("restart_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("restart_cpu_run", 32'(cpu_run), 32'd0);
        tick();
        chk("restart_run_state", 32'(state), 32'd2);
        chk("restart_run_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        chk("restart_run_cpu_run", 32'(cpu_run), 32'd1);

        // ld_start and restart in RUN are ignored
        ld_start = 1'b1;
        restart  = 1'b1;
        tick();
        ld_start = 1'b0;
        restart  = 1'b0;
        tick();
        chk("run_ignore_state", 32'(state), 32'd2);
        chk("run_ignore_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        chk("run_ignore_ld_ready", 32'(ld_ready), 32'd0);

        // Reload from HALTED with ld_start and restart together
        do_halt("halt4");
        chk("halted_ovf_sticky", 32'(ovf), 32'd1);
        ld_start = 1'b1;
        restart  = 1'b1;
        tick();
        ld_start  = 1'b0;
        restart   = 1'b0;
        m_loading = 1'b1;
        m_cnt     = 0;
        chk("reload_state", 32'(state), 32'd1);
        chk("reload_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("reload_cpu_run", 32'(cpu_run), 32'd0);
        chk("reload_ovf", 32'(ovf), 32'd0);
        chk("reload_ready", 32'(ld_ready), 32'd1);
        drive_byte(1'b1, 8'hC3, 1'b1);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check_run_entry("reload_run", 1, 1'b0);

        tick();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_loader_arb.md
Name: prog_loader_arb

Overview:
- Boot/load controller and memory arbiter for the 8-bit accumulator CPU (3-bit opcode, 5-bit address, 32x8 unified memory).
- Streams a program image over a valid/ready byte handshake into the shared memory.
- Then releases the CPU, hands it the memory port, and parks it when it halts.
- Sits between the top-level integration, the CPU core and the memory. Owns the memory port mux and the CPU run/reset controls.

Parameters:
- AW, 5, memory address width
- DW, 8, data width
- DEPTH, 32, memory words; must equal 2**AW

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ld_start  in  1  request a (re)load; sampled in IDLE/HALTED only
- ld_valid  in  1  loader byte valid
- ld_data  in  DW  loader byte
- ld_last  in  1  qualifies the final byte of the image
- ld_ready  out  1  loader may transfer; high only in LOAD
- restart  in  1  re-run the loaded program; sampled in HALTED only
- cpu_halt  in  1  CPU halt indication
- cpu_addr  in  AW  CPU memory address
- cpu_we  in  1  CPU memory write
- cpu_wdata  in  DW  CPU write data
- mem_addr  out  AW  arbitrated memory address
- mem_we  out  1  arbitrated memory write
- mem_wdata  out  DW  arbitrated write data
- cpu_rst_n  out  1  active-low CPU reset
- cpu_run  out  1  CPU clock-enable/run
- img_len  out  AW+1  bytes in the loaded image (0..DEPTH)
- ovf  out  1  sticky: image truncated at DEPTH bytes
- state  out  2  FSM state: IDLE=0, LOAD=1, RUN=2, HALTED=3

Behaviour:
- Reset (reset=0, async): state=IDLE, load counter=0, img_len=0, ovf=0, cpu_rst_n=0, cpu_run=0, ld_ready=0, mem_we=0.
  - A reset mid-LOAD leaves the memory contents undefined.
- Transfer rule: a byte transfers on a clock edge with ld_valid&&ld_ready.
  - Memory write is combinational in that same cycle: mem_addr=cnt, mem_wdata=ld_data, mem_we=1. One byte per cycle max; zero extra latency.
- IDLE:
  - cpu_rst_n=0, cpu_run=0. Memory port idle (mem_we=0, mem_addr=0).
  - ld_start -> LOAD; cnt cleared, ovf cleared.
- LOAD:
  - ld_ready=1. Each transfer writes mem[cnt] and does cnt++.
  - Transfer with ld_last=1 -> RUN next cycle; img_len=cnt+1.
  - Transfer at cnt=DEPTH-1 with ld_last=0: ovf=1, img_len=DEPTH, -> RUN. cnt never wraps.
  - ld_ready=0 from the cycle after the final transfer.
  - ld_valid=0 stalls indefinitely. No timeout.
  - ld_start is ignored.
- RUN:
  - cpu_rst_n=1, cpu_run=1. Memory port is a pure combinational pass-through of cpu_addr/cpu_we/cpu_wdata.
  - cpu_halt=1 -> HALTED. cpu_run deasserts in the next cycle.
  - ld_start and restart are ignored (no abort of a running program).
- HALTED:
  - cpu_run=0, cpu_rst_n=1, so CPU registers stay observable. Memory port stays muxed to the CPU with mem_we forced 0.
  - ld_start -> LOAD: cpu_rst_n=0 from the next cycle.
  - restart -> one cycle with cpu_rst_n=0, cpu_run=0, then RUN.
  - ld_start and restart asserted together: ld_start wins.
- Arbitration: the memory owner is a function of state only (LOAD=loader, RUN/HALTED=CPU, IDLE=none). There are no simultaneous-owner cases.
- Width rules:
  - cnt is AW+1 bits so DEPTH is representable.
  - img_len holds its value until the next LOAD entry.
  - ovf is sticky until the next LOAD entry.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE/LOAD/RUN/HALTED)
  - AW/DW/DEPTH defaults, also reused by the CPU control unit and datapath
- One natural sub-module: mem_port_mux, combinational owner-select of addr/we/wdata.
- FSM and counter stay in the top.

Test Plan:
- Reset: hold reset=0 mid-stream -> all outputs at reset values, state=0. Release -> stays IDLE.
- Normal load: ld_start, then 4 bytes 0xA3,0x04,0xE0,0x00 with last on the 4th -> mem[0..3] written in order, img_len=4, ovf=0, cpu_rst_n=1 and cpu_run=1 the cycle after.
- Stalls: 3-byte image with ld_valid gaps of 2 cycles -> no writes during gaps, cnt holds, img_len=3.
- Overflow: 40 bytes, no ld_last -> exactly 32 writes (addr 0..31), ovf=1, img_len=32, ld_ready=0 after byte 32, state=RUN.
- Halt/restart: in RUN drive cpu_we=1, cpu_addr=0x1F -> mem_we mirrors it. Assert cpu_halt -> state=3, mem_we=0. Pulse restart -> one-cycle cpu_rst_n=0, then RUN. Pulse ld_start in RUN -> ignored.
- Reload from HALTED: ld_start with restart same cycle -> LOAD, cpu_rst_n=0, cnt=0, ovf cleared.
